stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//  Inverse of the select-mux: routes one valid/ready input stream to one of N
//  output streams, chosen per word by a select field. Registered output stage,
//  1-cycle latency, full throughput. Fans a shared producer out to per-channel
//  consumers.
// PARAMETERS
//  N      4   number of output channels, N >= 2
//  W      8   data width in bits
//  SEL_W  $clog2(N)  select width; derived, do not override
//  CNT_W  16  width of per-channel counters (DEMUX_COUNT_EN only)
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  up_valid    in   1        input word valid
//  up_ready    out  1        input word accepted when up_valid & up_ready
//  up_data     in   W        input word
//  up_sel      in   SEL_W    destination channel for up_data
//  down_valid  out  N        per-channel valid, at most one bit set
//  down_ready  in   N        per-channel ready
//  down_data   out  W        shared data bus, qualified by down_valid[i]
//  sel_err     out  1        1-cycle pulse: word with up_sel >= N was dropped
//  down_cnt    out  N*CNT_W  per-channel delivered-word counters (DEMUX_COUNT_EN)
// BEHAVIOUR
//  - State: one holding register {full_q, sel_q, data_q}.
//  - Reset (rst_n low, async): full_q=0, sel_q=0, data_q=0, sel_err=0,
//    down_cnt=0. Therefore down_valid=0 and up_ready=1 while in reset.
//  - down_valid[i] = full_q & (sel_q == i); down_data = data_q.
//  - drain = full_q & down_ready[sel_q].
//  - up_ready = !full_q | drain (combinational, no up_valid dependency).
//  - Accept (up_valid & up_ready) with up_sel < N: load data_q/sel_q,
//    full_q=1. Word is on down_* on the next cycle (latency 1).
//  - Drain without accept: full_q=0.
//  - Simultaneous drain+accept: register reloads; back-to-back 1 word/clk.
//  - up_sel >= N (only when N is not a power of 2): word accepted, dropped,
//    sel_err=1 for one cycle. If no drain occurs, full_q/data_q are unchanged.
//  - Output stability: while down_valid[i]=1 and down_ready[i]=0, down_data
//    and down_valid hold. No other channel is served; no reordering.
//  - down_ready on a non-selected channel is ignored.
//  - Reset mid-transfer: the held word is discarded; no partial delivery.
//  - up_data and up_sel are don't-care when up_valid=0.
// CONFIGURATION
//  DEMUX_COUNT_EN defined: down_cnt[i] increments on each down_valid[i] &
//    down_ready[i] and saturates at 2**CNT_W-1.
//  DEMUX_COUNT_EN undefined: counter logic is absent and down_cnt is tied to 0.
//    The port stays in the port list.
// STRUCTURE
//  - stream_demux_pkg: localparams for default N/W/CNT_W; function
//    sel_w(n) = (n>1) ? $clog2(n) : 1; typedef sel_t.
//  - One sub-module, stream_demux_cnt: a saturating CNT_W counter with an inc
//    input, instantiated N times in a generate loop under DEMUX_COUNT_EN.
//  - Demux decode and holding register are inline. No FSM beyond full_q.
// TESTING
//  1. Reset release, no traffic: down_valid=0, up_ready=1, sel_err=0,
//     down_cnt=0.
//  2. up_sel=2, up_data=8'hA5, all ready: down_valid=4'b0100 and
//     down_data=A5 one cycle later; then idle.
//  3. Stream sel 0,1,2,3,0 with data 1..5, all ready: 5 words in 5 consecutive
//     cycles, in order, each on the correct channel.
//  4. down_ready[1]=0 for 4 cycles while holding word 8'h3C for ch1:
//     up_ready=0 and down_* stable; ready=1 drains it and up_ready=1 in the
//     same cycle.
//  5. N=3, up_sel=3: sel_err pulses once, no down_valid, next legal word is
//     unaffected.
//  6. rst_n low while full with ch0 stalled: down_valid=0 immediately
//     (async); after release the word does not reappear.
//     With DEMUX_COUNT_EN and CNT_W=2: 5 words to ch0 gives down_cnt[0]=3.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared defaults and select-width helper for the stream demux.
package stream_demux_pkg;
   localparam int N_DEF     = 4;
   localparam int W_DEF     = 8;
   localparam int CNT_W_DEF = 16;
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   typedef logic [sel_w(N_DEF)-1:0] sel_t;
endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: upstream valid/ready stream plus N downstream channels.
interface stream_demux_if
   import stream_demux_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   localparam int SEL_W = sel_w(N);
   logic               up_valid;
   logic               up_ready;
   logic [W-1:0]       up_data;
   logic [SEL_W-1:0]   up_sel;
   logic [N-1:0]       down_valid;
   logic [N-1:0]       down_ready;
   logic [W-1:0]       down_data;
   logic               sel_err;
   logic [N*CNT_W-1:0] down_cnt;
   modport master (
      input  up_valid, up_data, up_sel, down_ready,
      output up_ready, down_valid, down_data, sel_err, down_cnt
   );
   modport slave (
      output up_valid, up_data, up_sel, down_ready,
      input  up_ready, down_valid, down_data, sel_err, down_cnt
   );
endinterface

// File: rtl/stream_demux_cnt.sv
// stream_demux_cnt: saturating delivered-word counter for one channel.
module stream_demux_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
   assign o_cnt = r_cnt;
endmodule

// File: rtl/stream_demux.sv
// stream_demux: routes one valid/ready stream to one of N channels, 1-cycle latency.
// Optional per-channel delivered-word counters when DEMUX_COUNT_EN is defined.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic            clk,
   input logic            rst_n,
   stream_demux_if.master bus
);
   localparam int SEL_W = sel_w(N);
   logic             r_full;
   logic [SEL_W-1:0] r_sel;
   logic [W-1:0]     r_data;
   logic             r_err;
   logic [N-1:0]     w_valid;
   logic             w_drain;
   logic             w_acc;
   logic             w_legal;
   for (genvar g = 0; g < N; g++) begin : g_dec
      assign w_valid[g] = r_full & (r_sel == SEL_W'(g));
   end
   // drain found via the decoded valid so an out-of-range sel never indexes down_ready
   assign w_drain = |(w_valid & bus.down_ready);
   assign w_acc   = bus.up_valid & bus.up_ready;
   assign w_legal = int'(bus.up_sel) < N;
   assign bus.up_ready   = !r_full | w_drain;
   assign bus.down_valid = w_valid;
   assign bus.down_data  = r_data;
   assign bus.sel_err    = r_err;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_full <= 1'b0;
         r_sel  <= '0;
         r_data <= '0;
         r_err  <= 1'b0;
      end else begin
         r_err <= w_acc & !w_legal;
         if (w_acc && w_legal) begin
            r_full <= 1'b1;
            r_sel  <= bus.up_sel;
            r_data <= bus.up_data;
         end else if (w_drain) r_full <= 1'b0;
      end
`ifdef DEMUX_COUNT_EN
   for (genvar g = 0; g < N; g++) begin : g_cnt
      stream_demux_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .i_inc (w_valid[g] & bus.down_ready[g]),
         .o_cnt (bus.down_cnt[g*CNT_W +: CNT_W])
      );
   end
`else
   assign bus.down_cnt = '0;
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed scoreboard bench for an N=4 and an N=3 demux.
module tb_stream_demux;
`ifdef DEMUX_COUNT_EN
   localparam int CW = 2;
`else
   localparam int CW = 16;
`endif
   typedef struct packed {logic [1:0] ch; logic [7:0] d;} exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t e;
   always #5 clk = ~clk;
   stream_demux_if #(.N(4), .W(8), .CNT_W(CW)) a ();
   stream_demux_if #(.N(3), .W(8), .CNT_W(CW)) b ();
   stream_demux #(.N(4), .W(8), .CNT_W(CW)) u4 (.clk(clk), .rst_n(rst_n), .bus(a.master));
   stream_demux #(.N(3), .W(8), .CNT_W(CW)) u3 (.clk(clk), .rst_n(rst_n), .bus(b.master));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // handshakes are evaluated mid-cycle, then one clock edge is taken
   task automatic tick();
      @(negedge clk);
      chk("onehot", 64'($countones(a.down_valid) <= 1), 64'(1));
      for (int i = 0; i < 4; i++)
         if (a.down_valid[i] && a.down_ready[i]) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected: observed ch%0d data %0h expected no word", i, a.down_data);
            end else begin
               e = q.pop_front();
               chk("sb_ch", 64'(i), 64'(e.ch));
               chk("sb_data", 64'(a.down_data), 64'(e.d));
            end
         end
      if (a.up_valid && a.up_ready) q.push_back({a.up_sel, a.up_data});
      @(posedge clk);
      #1;
   endtask

   initial begin
      a.up_valid = 0; a.up_data = 0; a.up_sel = 0; a.down_ready = '1;
      b.up_valid = 0; b.up_data = 0; b.up_sel = 0; b.down_ready = '1;
      #12;
      chk("rst_valid", 64'(a.down_valid), 64'(0));
      chk("rst_ready", 64'(a.up_ready), 64'(1));
      chk("rst_err", 64'(a.sel_err), 64'(0));
      chk("rst_cnt", 64'(a.down_cnt), 64'(0));
      rst_n = 1'b1;
      tick(); tick();
      chk("idle_valid", 64'(a.down_valid), 64'(0));
      chk("idle_ready", 64'(a.up_ready), 64'(1));
      chk("idle_err", 64'(a.sel_err), 64'(0));
      // single word to ch2
      a.up_valid = 1; a.up_sel = 2; a.up_data = 8'hA5;
      tick();
      a.up_valid = 0;
      chk("t2_valid", 64'(a.down_valid), 64'(4'b0100));
      chk("t2_data", 64'(a.down_data), 64'(8'hA5));
      tick();
      chk("t2_idle", 64'(a.down_valid), 64'(0));
      // back-to-back stream
      for (int k = 0; k < 5; k++) begin
         a.up_valid = 1; a.up_sel = 2'(k % 4); a.up_data = 8'(k + 1);
         #1;
         chk("t3_ready", 64'(a.up_ready), 64'(1));
         tick();
         chk("t3_valid", 64'(a.down_valid), 64'(1 << (k % 4)));
         chk("t3_data", 64'(a.down_data), 64'(k + 1));
      end
      a.up_valid = 0;
      tick();
      chk("t3_empty", 64'(q.size()), 64'(0));
      // stall ch1 while a second word waits upstream
      a.down_ready = 4'b1101;
      a.up_valid = 1; a.up_sel = 1; a.up_data = 8'h3C;
      tick();
      a.up_sel = 0; a.up_data = 8'h77;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t4_ready", 64'(a.up_ready), 64'(0));
         chk("t4_valid", 64'(a.down_valid), 64'(4'b0010));
         chk("t4_data", 64'(a.down_data), 64'(8'h3C));
         tick();
      end
      a.down_ready = '1;
      #1;
      chk("t4_drain_ready", 64'(a.up_ready), 64'(1));
      tick();
      a.up_valid = 0;
      chk("t4_next_valid", 64'(a.down_valid), 64'(4'b0001));
      chk("t4_next_data", 64'(a.down_data), 64'(8'h77));
      tick();
      chk("t4_idle", 64'(a.down_valid), 64'(0));
      // illegal select on the N=3 instance
      b.up_valid = 1; b.up_sel = 3; b.up_data = 8'hEE;
      #1;
      chk("t5_ready", 64'(b.up_ready), 64'(1));
      tick();
      b.up_valid = 0;
      chk("t5_err", 64'(b.sel_err), 64'(1));
      chk("t5_valid", 64'(b.down_valid), 64'(0));
      b.up_valid = 1; b.up_sel = 2; b.up_data = 8'h42;
      tick();
      b.up_valid = 0;
      chk("t5_err_clr", 64'(b.sel_err), 64'(0));
      chk("t5_legal_valid", 64'(b.down_valid), 64'(3'b100));
      chk("t5_legal_data", 64'(b.down_data), 64'(8'h42));
      tick();
      chk("t5_idle", 64'(b.down_valid), 64'(0));
      chk("cnt_tied", 64'(a.down_cnt == 0), 64'(`ifdef DEMUX_COUNT_EN 0 `else 1 `endif));
      // async reset while ch0 is stalled
      a.down_ready = 4'b1110;
      a.up_valid = 1; a.up_sel = 0; a.up_data = 8'h5A;
      tick();
      a.up_valid = 0;
      tick();
      chk("t6_held", 64'(a.down_valid), 64'(4'b0001));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(a.down_valid), 64'(0));
      chk("t6_rst_ready", 64'(a.up_ready), 64'(1));
      q.delete();
      #2;
      rst_n = 1'b1;
      a.down_ready = '1;
      tick(); tick();
      chk("t6_gone", 64'(a.down_valid), 64'(0));
      chk("t6_empty", 64'(q.size()), 64'(0));
`ifdef DEMUX_COUNT_EN
      for (int k = 0; k < 5; k++) begin
         a.up_valid = 1; a.up_sel = 0; a.up_data = 8'(8'h10 + k);
         tick();
      end
      a.up_valid = 0;
      tick();
      chk("cnt_sat", 64'(a.down_cnt[CW-1:0]), 64'(3));
      chk("cnt_other", 64'(a.down_cnt[4*CW-1:CW]), 64'(0));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
